// File: rtl/restore_div_pkg.sv
// Shared types and elaboration helpers for the handshaked restoring divider.
package restore_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic int iter_count(input int dividend_w, input int bits_per_cycle);
        return dividend_w / bits_per_cycle;
    endfunction

    function automatic int cnt_width(input int iter);
        return (iter < 2) ? 1 : $clog2(iter + 1);
    endfunction

    function automatic bit params_ok(input int dividend_w, input int divisor_w, input int bits_per_cycle);
        return (dividend_w >= 2) && (divisor_w >= 2) && (divisor_w <= dividend_w) &&
               (bits_per_cycle >= 1) && ((dividend_w % bits_per_cycle) == 0) &&
               ((bits_per_cycle & (bits_per_cycle - 1)) == 0);
    endfunction

endpackage

// File: rtl/restore_div_step.sv
// One combinational restoring step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module restore_div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W-1:0] rem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] div_i,
    output logic [DIVISOR_W-1:0] rem_o,
    output logic                 q_o
);

    // The extra top bit is the guard that lets divisors with MSB set work.
    logic [DIVISOR_W:0] trial;

    assign trial = {rem_i, bit_i};
    assign q_o   = (trial >= {1'b0, div_i});
    assign rem_o = q_o ? DIVISOR_W'(trial - {1'b0, div_i}) : trial[DIVISOR_W-1:0];

endmodule

// File: rtl/restore_divider_hs.sv
// Multi-cycle restoring divider with valid/ready on both sides, signed or
// unsigned per operation, and divide-by-zero / signed-overflow flags.
module restore_divider_hs
    import restore_div_pkg::*;
#(
    parameter int DIVIDEND_W     = 16,
    parameter int DIVISOR_W      = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int ITER  = iter_count(DIVIDEND_W, BITS_PER_CYCLE);
    localparam int CNT_W = cnt_width(ITER);

    if (!params_ok(DIVIDEND_W, DIVISOR_W, BITS_PER_CYCLE)) begin : g_param_check
        $error("restore_divider_hs: illegal parameter combination");
    end

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] dq_q;
    logic [DIVISOR_W-1:0]  rem_q, div_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  q_neg_q, r_neg_q, mode_q, ovf_q;
    logic                  out_valid_q, div_by_zero_q, overflow_q;
    logic [DIVIDEND_W-1:0] quotient_q;
    logic [DIVISOR_W-1:0]  remainder_q;

    logic                  accept, dz_in, a_neg, b_neg, ovf_in;
    logic [DIVIDEND_W-1:0] a_abs, dq_step;
    logic [DIVISOR_W-1:0]  b_abs, rem_step;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign dz_in    = (divisor == '0);
    assign a_neg    = signed_mode && dividend[DIVIDEND_W-1];
    assign b_neg    = signed_mode && divisor[DIVISOR_W-1];
    assign a_abs    = a_neg ? -dividend : dividend;
    assign b_abs    = b_neg ? -divisor : divisor;
    assign ovf_in   = signed_mode && (dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (divisor == '1);

    // dq_q starts as |dividend| and fills with quotient bits from the LSB end.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        logic [DIVISOR_W-1:0]  rem_in, rem_out;
        logic [DIVIDEND_W-1:0] dq_in, dq_out;
        logic                  q_bit;

        if (i == 0) begin : g_head
            assign rem_in = rem_q;
            assign dq_in  = dq_q;
        end else begin : g_link
            assign rem_in = g_step[i-1].rem_out;
            assign dq_in  = g_step[i-1].dq_out;
        end

        restore_div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
            .rem_i (rem_in),
            .bit_i (dq_in[DIVIDEND_W-1]),
            .div_i (div_q),
            .rem_o (rem_out),
            .q_o   (q_bit)
        );

        assign dq_out = {dq_in[DIVIDEND_W-2:0], q_bit};
    end

    assign dq_step  = g_step[BITS_PER_CYCLE-1].dq_out;
    assign rem_step = g_step[BITS_PER_CYCLE-1].rem_out;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = dz_in ? DONE : CALC;
            CALC: if (cnt_q == CNT_W'(ITER - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                if (accept)         state_d = dz_in ? DONE : CALC;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_q          <= '0;
            rem_q         <= '0;
            div_q         <= '0;
            cnt_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            mode_q        <= 1'b0;
            ovf_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
        end else if (accept) begin
            dq_q          <= a_abs;
            rem_q         <= '0;
            div_q         <= b_abs;
            cnt_q         <= '0;
            q_neg_q       <= a_neg ^ b_neg;
            r_neg_q       <= a_neg;
            mode_q        <= signed_mode;
            ovf_q         <= ovf_in;
            overflow_q    <= 1'b0;
            div_by_zero_q <= dz_in;
            out_valid_q   <= dz_in;
            if (dz_in) begin
                quotient_q  <= '1;
                remainder_q <= dividend[DIVISOR_W-1:0];
            end
        end else begin
            case (state_q)
                CALC: begin
                    dq_q  <= dq_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    quotient_q  <= (mode_q && q_neg_q) ? -dq_q : dq_q;
                    remainder_q <= (mode_q && r_neg_q) ? -rem_q : rem_q;
                    overflow_q  <= ovf_q;
                    out_valid_q <= 1'b1;
                end
                DONE: if (out_ready) out_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_restore_divider_hs.sv
// Scoreboard bench for restore_divider_hs: a driver pushes expected results,
// an independent monitor pops and compares on every presented result.
module tb_restore_divider_hs;

    localparam int DW   = 16;
    localparam int VW   = 8;
    localparam int ITER = 16;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        logic          ov;
        int            lat;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready, signed_mode = 1'b0;
    logic [DW-1:0] dividend = '0, quotient;
    logic [VW-1:0] divisor = '0, remainder;
    logic          out_valid, out_ready = 1'b1, div_by_zero, overflow;

    logic          in_valid4 = 1'b0, in_ready4, signed4 = 1'b0;
    logic [DW-1:0] dividend4 = '0, quotient4;
    logic [VW-1:0] divisor4 = '0, remainder4;
    logic          out_valid4, out_ready4 = 1'b1, div_by_zero4, overflow4;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, cyc = 0, ord_mode = 0;

    restore_divider_hs u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    restore_divider_hs #(.BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .dividend(dividend4), .divisor(divisor4), .signed_mode(signed4),
        .out_valid(out_valid4), .out_ready(out_ready4), .quotient(quotient4),
        .remainder(remainder4), .div_by_zero(div_by_zero4), .overflow(overflow4)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer division (truncates toward zero, remainder takes dividend sign).
    function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s,
                                  output logic [DW-1:0] q, output logic [VW-1:0] r,
                                  output logic dz, output logic ov);
        int ai, bi, qi, ri;
        dz = 1'b0; ov = 1'b0;
        if (b == '0) begin
            q = '1; r = a[VW-1:0]; dz = 1'b1;
        end else begin
            if (s) begin ai = $signed(a); bi = $signed(b); end
            else   begin ai = int'({16'd0, a}); bi = int'({24'd0, b}); end
            if (s && ai == -(2 ** (DW - 1)) && bi == -1) begin
                q = {1'b1, {(DW-1){1'b0}}}; r = '0; ov = 1'b1;
            end else begin
                qi = ai / bi; ri = ai % bi;
                q = qi[DW-1:0]; r = ri[VW-1:0];
            end
        end
    endfunction

    initial forever begin
        @(negedge clk);
        case (ord_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz, input logic eov);
        exp_t e;
        bit   done = 0;
        @(negedge clk);
        dividend = a; divisor = b; signed_mode = s; in_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            #1;
            if (in_ready) begin
                e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
                e.lat = edz ? 1 : ITER + 2; e.acc = cyc;
                sb.push_back(e);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue_model(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s);
        logic [DW-1:0] q; logic [VW-1:0] r; logic dz, ov;
        model(a, b, s, q, r, dz, ov);
        issue(a, b, s, q, r, dz, ov);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic run4(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s);
        logic [DW-1:0] q; logic [VW-1:0] r; logic dz, ov;
        int lat;
        model(a, b, s, q, r, dz, ov);
        @(negedge clk);
        dividend4 = a; divisor4 = b; signed4 = s; in_valid4 = 1'b1;
        #1 chk("in_ready4", 32'(in_ready4), 32'd1);
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("latency4", 32'(lat), dz ? 32'd1 : 32'd6);
        chk("quotient4", 32'(quotient4), 32'(q));
        chk("remainder4", 32'(remainder4), 32'(r));
        chk("flags4", {30'd0, div_by_zero4, overflow4}, {30'd0, dz, ov});
        @(posedge clk);
        #1 chk("out_valid4_clear", 32'(out_valid4), 32'd0);
    endtask

    // Monitor: compares a result on first presentation, then checks it stays put until taken.
    initial begin
        exp_t e;
        bit seen = 0;
        logic [DW+VW+1:0] cap = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                seen = 0;
                continue;
            end
            if (out_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out_valid", 32'd1, 32'd0);
                    end else begin
                        e = sb[0];
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                        chk("quotient", 32'(quotient), 32'(e.q));
                        chk("remainder", 32'(remainder), 32'(e.r));
                        chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                        chk("overflow", 32'(overflow), 32'(e.ov));
                    end
                    cap  = {quotient, remainder, div_by_zero, overflow};
                    seen = 1;
                end else begin
                    chk("hold_stable", 32'({quotient, remainder, div_by_zero, overflow}), 32'(cap));
                end
                if (out_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic          s;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run4(16'd1000, 8'd7, 1'b0);
        run4(16'hFC18, 8'd7, 1'b1);
        run4(16'h1234, 8'd0, 1'b0);
        for (int k = 0; k < 6; k++) run4(16'($urandom), 8'($urandom), 1'($urandom));

        issue(16'd1000, 8'd7, 1'b0, 16'd142, 8'd6, 1'b0, 1'b0);
        issue(16'hFC18, 8'd7, 1'b1, 16'hFF72, 8'hFA, 1'b0, 1'b0);
        issue(16'd1000, 8'hF9, 1'b1, 16'hFF72, 8'h06, 1'b0, 1'b0);
        issue(16'h1234, 8'h00, 1'b0, 16'hFFFF, 8'h34, 1'b1, 1'b0);
        issue(16'h8000, 8'hFF, 1'b1, 16'h8000, 8'h00, 1'b0, 1'b1);
        issue(16'h8000, 8'hFF, 1'b0, 16'h0080, 8'h80, 1'b0, 1'b0);
        drain();

        ord_mode = 2;
        issue(16'd1000, 8'd7, 1'b0, 16'd142, 8'd6, 1'b0, 1'b0);
        begin
            int t = 0;
            while (!out_valid && t < 100) begin @(negedge clk); #1; t++; end
            chk("stall_result_present", 32'(out_valid), 32'd1);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        ord_mode = 0;
        issue(16'd2000, 8'd3, 1'b0, 16'd666, 8'd2, 1'b0, 1'b0);
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        drain();

        issue(16'd40000, 8'd3, 1'b0, 16'd13333, 8'd1, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_outputs", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'd65535, 8'd255, 1'b0, 16'd257, 8'd0, 1'b0, 1'b0);
        drain();

        ord_mode = 1;
        for (int k = 0; k < 2000; k++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 9))
                0: b = 8'h00;
                1: begin a = 16'h8000; b = 8'hFF; end
                2: b = 8'h80;
                3: b = 8'hFF;
                4: a = 16'h8000;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue_model(a, b, s);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
